// File: rtl/fir_out_decimator.sv
// -----------------------------------------------------------------------------
// fir_out_decimator
//   Boxcar decimator placed after the 4-tap FIR filter. Every DECIM accepted
//   samples are summed and divided by DECIM. Each result is queued in a small
//   FIFO and offered to the next consumer on a valid/ready handshake. A sticky
//   flag records any result that was dropped because the FIFO was full.
//
// Build option:
//   FIR_OUT_DECIMATOR_ROUND_EN - when defined, results are rounded half up
//                                instead of truncated (applies to flush too).
//
// Parameters:
//   DECIM      - decimation factor (2, 4, 8 or 16)
//   FIFO_DEPTH - result FIFO entries (power of two, >= 2)
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-high reset
//   in_data    in   [7:0] filter output sample
//   in_en      in   sample strobe; in_data consumed on each edge with in_en=1
//   flush      in   one-cycle pulse: emit the partial block now
//   out_data   out  [7:0] FIFO head result (0 when empty)
//   out_valid  out  FIFO head is presentable
//   out_ready  in   consumer accepts out_data
//   fifo_level out  current FIFO entry count
//   overflow   out  sticky: a result was dropped
//   clr_ovf    in   clears overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module fir_out_decimator #(
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_en,
  input  logic                          flush,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int LOG2_DECIM = $clog2(DECIM);
  localparam int AW         = 8 + LOG2_DECIM;      // 255*DECIM fits, no wrap possible
  localparam int PW         = LOG2_DECIM;          // phase counter width
  localparam int PTRW       = $clog2(FIFO_DEPTH);
  localparam int LW         = PTRW + 1;

  // Divide a block total by DECIM, optionally rounding half up. The biased
  // total never exceeds 255*DECIM + DECIM/2 < 2**AW, so no extra bit is needed.
  function automatic logic [7:0] scale_result(input logic [AW-1:0] total);
    logic [AW-1:0] biased;
`ifdef FIR_OUT_DECIMATOR_ROUND_EN
    biased = total + AW'(DECIM / 2);
`else
    biased = total;
`endif
    scale_result = 8'(biased >> LOG2_DECIM);
  endfunction

  logic [AW-1:0]   acc_r;
  logic [PW-1:0]   phase_r;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [PTRW-1:0] wr_ptr_r;
  logic [PTRW-1:0] rd_ptr_r;
  logic [LW-1:0]   count_r;
  logic            out_valid_r;
  logic [7:0]      out_data_r;
  logic            overflow_r;

  logic [AW-1:0]   addend_s;
  logic [AW-1:0]   sum_s;
  logic            complete_s;
  logic            flush_push_s;
  logic            push_s;
  logic [7:0]      result_s;
  logic            pop_s;
  logic            full_s;
  logic            write_s;
  logic            drop_s;
  logic [LW-1:0]   remain_s;
  logic [PTRW-1:0] head_ptr_s;

  // Block completion, push/pop decisions and next head selection.
  always_comb begin
    addend_s     = in_en ? AW'(in_data) : {AW{1'b0}};
    sum_s        = acc_r + addend_s;
    complete_s   = in_en && (phase_r == PW'(DECIM - 1));
    // A flush pushes only when there is something to emit: either a partial
    // block already accumulated or a sample arriving in the flush cycle.
    flush_push_s = flush && ((phase_r != {PW{1'b0}}) || in_en);
    push_s       = complete_s || flush_push_s;
    result_s     = scale_result(sum_s);
    pop_s        = out_valid_r && out_ready;
    full_s       = (count_r == LW'(FIFO_DEPTH));
    write_s      = push_s && (!full_s || pop_s);
    drop_s       = push_s && full_s && !pop_s;
    // Entries that existed before this edge and survive the pop. Only these
    // may be presented next cycle, so a fresh push surfaces one edge later.
    remain_s     = count_r - LW'(pop_s);
    head_ptr_s   = rd_ptr_r + PTRW'(pop_s);
  end

  // Accumulator and phase counter; a push always starts a fresh block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r   <= {AW{1'b0}};
      phase_r <= {PW{1'b0}};
    end else if (push_s) begin
      acc_r   <= {AW{1'b0}};
      phase_r <= {PW{1'b0}};
    end else if (in_en) begin
      acc_r   <= sum_s;
      phase_r <= phase_r + PW'(1);
    end else begin
      acc_r   <= acc_r;
      phase_r <= phase_r;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_r[wr_ptr_r] <= result_s;
    end
  end

  // FIFO pointers, level, registered head and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r    <= {PTRW{1'b0}};
      rd_ptr_r    <= {PTRW{1'b0}};
      count_r     <= {LW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= 8'd0;
      overflow_r  <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_r + PTRW'(write_s);
      rd_ptr_r    <= head_ptr_s;
      count_r     <= count_r + LW'(write_s) - LW'(pop_s);
      out_valid_r <= (remain_s != {LW{1'b0}});
      out_data_r  <= (remain_s != {LW{1'b0}}) ? mem_r[head_ptr_s] : 8'd0;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign out_data   = out_data_r;
  assign out_valid  = out_valid_r;
  assign fifo_level = count_r;
  assign overflow   = overflow_r;

endmodule

// File: doc/fir_out_decimator.md
Name: fir_out_decimator

Overview:
- Downstream stage of the 4-tap FIR filter. Consumes the filter's 8-bit output sample stream.
- Averages every DECIM consecutive samples (boxcar decimation).
- Buffers the averaged results in a small FIFO and presents them on a valid/ready handshake to the next consumer (host readout / uio logic).
- Reports buffer overflow with a sticky flag.

Parameters:
- DECIM, 4: decimation factor; legal values 2, 4, 8, 16 (power of two); LOG2_DECIM derived locally.
- FIFO_DEPTH, 4: result FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  filter output sample.
- in_en  input  1  sample strobe; in_data is consumed on each clk edge where in_en=1.
- flush  input  1  one-cycle pulse; emit the partial block now.
- out_data  output  8  FIFO head result.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data.
- fifo_level  output  LOG2(FIFO_DEPTH)+1  current entry count.
- overflow  output  1  sticky: a result was dropped.
- clr_ovf  input  1  clears overflow.

Behaviour:
- Reset (async, reset=1), effective immediately, including mid-block:
  - acc=0, phase counter=0, FIFO pointers=0.
  - out_valid=0, out_data=0, fifo_level=0, overflow=0.
- Accumulator:
  - Width 8+LOG2_DECIM bits, unsigned.
  - On in_en=1: acc <= acc + in_data and phase <= phase+1.
  - When phase==DECIM-1 and in_en=1, the block completes. result = (acc + in_data) >> LOG2_DECIM, truncated.
  - On completion, push result; acc <= 0; phase <= 0.
  - No wrap or overflow is possible in acc.
- Flush:
  - flush=1 with phase>0: push (acc, including in_data if in_en=1) >> LOG2_DECIM. This is the partial sum divided by DECIM, not by the sample count. Then clear acc and phase.
  - flush=1 with phase==0 and in_en=0: no push.
  - flush coincident with block completion: single push only.
- Push timing: the result is written to the FIFO on the same edge the block completes. out_valid rises on the following edge if the FIFO was empty, giving 1-cycle latency from the last sample edge to out_valid=1.
- FIFO:
  - A pop occurs when out_valid && out_ready.
  - out_data = head entry, registered; it is 0 when empty.
  - Order is strictly first-in, first-out.
  - Push while full without a pop: the new result is dropped, overflow <= 1, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both occur, no overflow, level unchanged.
  - Push and pop in the same cycle while non-empty: level unchanged.
  - Pop while empty: ignored.
- overflow:
  - Set by a drop; cleared by clr_ovf=1.
  - A drop and clr_ovf in the same cycle leave overflow=1 (set wins).
- in_en=0 holds acc and phase; the FIFO side keeps operating.
- No combinational path from in_data to any output.

Optional Feature:
- Macro: FIR_OUT_DECIMATOR_ROUND_EN.
- Defined: result = (acc_total + DECIM/2) >> LOG2_DECIM (round half up). The maximum is (255*DECIM + DECIM/2) >> LOG2_DECIM = 255, so no saturation is needed. Flush rounding uses the same formula.
- Undefined: truncation as described above.

Test Plan:
- Reset and idle: assert reset mid-run with 2 entries queued -> out_valid=0, fifo_level=0, overflow=0, out_data=0 immediately. After release, the first result comes only after DECIM new samples.
- Basic decimation, DECIM=4, out_ready=1: in_data 10, 20, 30, 42 on consecutive in_en cycles -> out_data=25 (26 with ROUND_EN), out_valid=1 exactly one edge after the 42 sample. Repeat with in_en gaps -> same result.
- Backpressure and overflow: out_ready=0, five blocks of constant samples 1, 2, 3, 4, 5 -> fifo_level=4, overflow=1. Drain with out_ready=1 -> 1, 2, 3, 4 in order. Pulse clr_ovf -> overflow=0.
- Full with simultaneous push and pop: FIFO full; block completion on the same cycle as a pop -> no overflow, level stays 4, new value appears last.
- Flush: samples 100, 100, then flush -> result (200)>>2 = 50 pushed, phase resets. Flush with phase=0 -> no push.
- Extremes: four samples of 255 -> 255, both with and without ROUND_EN. Four samples of 0 -> 0.
